mem_access_arbiter: RTL and testbench

// - Shares one single-ported, pipelined memory between instruction fetch (IF) and the data-memory stage (DM).
// - Formats DM requests: byte enables and store-data lane shift from funct3SType_e / funct3ITypeLOAD_e.
// - Returns responses in order; aligns and sign/zero-extends load data per funct3.

---
 rtl/mem_access_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Shares one single-ported, pipelined memory between instruction fetch and the data stage.
// It shapes data-stage accesses, returns responses in order and extends load data.
// Optional MEM_ALIGN_CHK_EN: misaligned or illegal data accesses get an error response and never reach memory.
module mem_access_arbiter #(
   parameter int MAX_OUTST    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [2:0]  dm_funct3,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCK_IF,
      ST_LOCK_DM
   } lock_state_e;

   // The write flag rides along so store acknowledges return zero data.
   typedef struct packed {
      logic       is_dm;
      logic       we;
      logic [2:0] funct3;
      logic [1:0] off;
   } entry_t;

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   lock_state_e   state_q, state_d;
   entry_t        fifo_q [MAX_OUTST];
   entry_t        head, new_entry;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [SW-1:0] starve_cnt_q;
   logic          fifo_full, fifo_empty, push, pop;
   logic          dm_bad, dm_cand, starve_at_max, starve_hit, sel_dm;
   logic          err_gnt, err_rsp_q, dm_rsp;
   logic [3:0]    be_base;
   logic [31:0]   shifted, load_data;
   logic          unused_if_addr;

   assign unused_if_addr = ^if_addr[1:0];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef MEM_ALIGN_CHK_EN
   // Illegal funct3 codes and misaligned half/word accesses are answered locally.
   always_comb begin
      dm_bad = 1'b0;
      if (dm_we) begin
         dm_bad = dm_funct3[2] | (dm_funct3[1:0] == 2'b11);
      end else begin
         dm_bad = (dm_funct3 == 3'b011) | (dm_funct3[2:1] == 2'b11);
      end
      if ((dm_funct3[1:0] == 2'b01) && dm_addr[0]) begin
         dm_bad = 1'b1;
      end
      if ((dm_funct3[1:0] == 2'b10) && (dm_addr[1:0] != 2'b00)) begin
         dm_bad = 1'b1;
      end
   end

   // Waiting for an empty pipe keeps the error response in order with memory responses.
   assign err_gnt = dm_req & dm_bad & fifo_empty & (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_rsp_q <= 1'b0;
      end else begin
         err_rsp_q <= err_gnt;
      end
   end
`else
   assign dm_bad    = 1'b0;
   assign err_gnt   = 1'b0;
   assign err_rsp_q = 1'b0;
`endif

   assign dm_cand       = dm_req & ~dm_bad;
   assign fifo_full     = (count_q == CW'(MAX_OUTST));
   assign fifo_empty    = (count_q == '0);
   assign starve_at_max = (starve_cnt_q == SW'(STARVE_LIMIT));
   assign starve_hit    = (STARVE_LIMIT != 0) && starve_at_max;

   // A stalled request keeps its source until memory accepts it.
   always_comb begin
      sel_dm = dm_cand & ~(if_req & starve_hit);
      case (state_q)
         ST_LOCK_IF: sel_dm = 1'b0;
         ST_LOCK_DM: sel_dm = 1'b1;
         default:    ;
      endcase
   end

   assign mem_req = (sel_dm ? dm_cand : if_req) & ~fifo_full & ~err_gnt;
   assign push    = mem_req & mem_gnt;
   assign pop     = mem_rvalid & ~fifo_empty;
   assign if_gnt  = push & ~sel_dm;
   assign dm_gnt  = (push & sel_dm) | err_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      if (mem_req && !mem_gnt) begin
         state_d = sel_dm ? ST_LOCK_DM : ST_LOCK_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else if (if_gnt) begin
         starve_cnt_q <= '0;
      end else if (push && sel_dm && if_req && !starve_at_max) begin
         starve_cnt_q <= starve_cnt_q + SW'(1);
      end
   end

   always_comb begin
      case (dm_funct3[1:0])
         2'b00:   be_base = 4'b0001;
         2'b01:   be_base = 4'b0011;
         2'b10:   be_base = 4'b1111;
         default: be_base = 4'b0000;
      endcase
   end

   // Memory side is driven only while a request is presented, otherwise all zero.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (mem_req) begin
         if (sel_dm) begin
            mem_we    = dm_we;
            mem_addr  = {dm_addr[31:2], 2'b00};
            mem_be    = be_base << dm_addr[1:0];
            mem_wdata = dm_we ? (dm_wdata << {dm_addr[1:0], 3'b000}) : 32'h0;
         end else begin
            mem_addr  = {if_addr[31:2], 2'b00};
            mem_be    = 4'b1111;
         end
      end
   end

   always_comb begin
      new_entry        = '0;
      new_entry.is_dm  = sel_dm;
      if (sel_dm) begin
         new_entry.we     = dm_we;
         new_entry.funct3 = dm_funct3;
         new_entry.off    = dm_addr[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < MAX_OUTST; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
            wr_ptr_q         <= next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign head = fifo_q[rd_ptr_q];

   always_comb begin
      shifted   = mem_rdata >> {head.off, 3'b000};
      load_data = shifted;
      case (head.funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: ;
      endcase
   end

   assign if_rvalid = pop & ~head.is_dm;
   assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
   assign dm_rsp    = pop & head.is_dm;
   assign dm_rvalid = dm_rsp | err_rsp_q;
   assign dm_rdata  = (dm_rsp && !head.we) ? load_data : 32'h0;
   assign dm_err    = err_rsp_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter (MAX_OUTST=2, STARVE_LIMIT=4).
`timescale 1ns/1ps
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [2:0]  dm_funct3;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_gnt, dm_rvalid, dm_err;
   logic [31:0] dm_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   int          n_checks = 0;
   int          n_fails  = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_funct3 = 0;
      dm_addr = 0; dm_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, dm_err, mem_we, mem_be} !== 10'b0) begin
         n_fails++;
         $display("[TB] FAIL reset_ctrl: got %b, want 0", {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, dm_err, mem_we, mem_be});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         n_fails++;
         $display("[TB] FAIL reset_data: got %h, want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
      end
      tick();
      rst_n = 1'b1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b00) begin
         n_fails++;
         $display("[TB] FAIL stale_rvalid: got %b, want 00", {if_rvalid, dm_rvalid});
      end
   endtask

   task automatic test_fetch();
      tick();
      mem_rvalid = 0; if_req = 1; if_addr = 32'h104; mem_gnt = 1;
      #1;
      n_checks++;
      if ({mem_req, if_gnt, dm_gnt, mem_we} !== 4'b1100) begin
         n_fails++;
         $display("[TB] FAIL fetch_grant: got %b, want 1100", {mem_req, if_gnt, dm_gnt, mem_we});
      end
      n_checks++;
      if (mem_addr !== 32'h104 || mem_be !== 4'hF) begin
         n_fails++;
         $display("[TB] FAIL fetch_addr: got %h/%b, want 00000104/1111", mem_addr, mem_be);
      end
      tick();
      if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'hDEAD_BEEF) begin
         n_fails++;
         $display("[TB] FAIL fetch_rsp: got %b/%h, want 10/deadbeef", {if_rvalid, dm_rvalid}, if_rdata);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3  [6];
      logic [31:0] ad  [6];
      logic [3:0]  be  [6];
      logic [31:0] exp_d [6];
      f3    = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b000};
      ad    = '{32'h203, 32'h202, 32'h200, 32'h201, 32'h204, 32'h200};
      be    = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b0001};
      exp_d = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_FF00, 32'h0000_00FF,
                32'h80FF_FF00, 32'h0000_0000};
      for (int i = 0; i < 6; i++) begin
         tick();
         mem_rvalid = 0; dm_req = 1; dm_we = 0; dm_funct3 = f3[i]; dm_addr = ad[i]; mem_gnt = 1;
         #1;
         n_checks++;
         if ({mem_req, dm_gnt, if_gnt, mem_we} !== 4'b1100) begin
            n_fails++;
            $display("[TB] FAIL load%0d_grant: got %b, want 1100", i, {mem_req, dm_gnt, if_gnt, mem_we});
         end
         n_checks++;
         if (mem_be !== be[i]) begin
            n_fails++;
            $display("[TB] FAIL load%0d_be: got %b, want %b", i, mem_be, be[i]);
         end
         n_checks++;
         if (mem_addr !== {ad[i][31:2], 2'b00}) begin
            n_fails++;
            $display("[TB] FAIL load%0d_addr: got %h, want %h", i, mem_addr, {ad[i][31:2], 2'b00});
         end
         tick();
         dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h80FF_FF00;
         #1;
         n_checks++;
         if ({dm_rvalid, if_rvalid, dm_err} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL load%0d_rvalid: got %b, want 100", i, {dm_rvalid, if_rvalid, dm_err});
         end
         n_checks++;
         if (dm_rdata !== exp_d[i]) begin
            n_fails++;
            $display("[TB] FAIL load%0d_data: got %h, want %h", i, dm_rdata, exp_d[i]);
         end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3 [4];
      logic [31:0] ad [4];
      logic [31:0] wd [4];
      logic [3:0]  be [4];
      logic [31:0] mw [4];
      f3 = '{3'b001, 3'b000, 3'b010, 3'b000};
      ad = '{32'h06, 32'h03, 32'h08, 32'h01};
      wd = '{32'h1234, 32'hAB, 32'hCAFE_F00D, 32'hA5};
      be = '{4'b1100, 4'b1000, 4'b1111, 4'b0010};
      mw = '{32'h1234_0000, 32'hAB00_0000, 32'hCAFE_F00D, 32'h0000_A500};
      for (int i = 0; i < 4; i++) begin
         tick();
         mem_rvalid = 0; dm_req = 1; dm_we = 1; dm_funct3 = f3[i];
         dm_addr = ad[i]; dm_wdata = wd[i]; mem_gnt = 1;
         #1;
         n_checks++;
         if ({mem_req, dm_gnt, if_gnt, mem_we} !== 4'b1101) begin
            n_fails++;
            $display("[TB] FAIL store%0d_grant: got %b, want 1101", i, {mem_req, dm_gnt, if_gnt, mem_we});
         end
         n_checks++;
         if (mem_be !== be[i] || mem_wdata !== mw[i]) begin
            n_fails++;
            $display("[TB] FAIL store%0d_lane: got %b/%h, want %b/%h", i, mem_be, mem_wdata, be[i], mw[i]);
         end
         n_checks++;
         if (mem_addr !== {ad[i][31:2], 2'b00}) begin
            n_fails++;
            $display("[TB] FAIL store%0d_addr: got %h, want %h", i, mem_addr, {ad[i][31:2], 2'b00});
         end
         tick();
         dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
         #1;
         n_checks++;
         if ({dm_rvalid, dm_err} !== 2'b10 || dm_rdata !== 32'h0) begin
            n_fails++;
            $display("[TB] FAIL store%0d_ack: got %b/%h, want 10/00000000", i, {dm_rvalid, dm_err}, dm_rdata);
         end
      end
   endtask

   // Both sources held; the fifth grant goes to fetch after four data wins.
   task automatic test_starvation();
      logic [0:5] g;
      g = 6'b111101;
      for (int i = 0; i < 7; i++) begin
         tick();
         if_req = (i < 6); dm_req = (i < 6); dm_we = 0; dm_funct3 = 3'b010;
         dm_addr = 32'h300; if_addr = 32'h400; mem_gnt = 1;
         mem_rvalid = (i > 0); mem_rdata = 32'h1000 + i;
         #1;
         if (i < 6) begin
            n_checks++;
            if ({mem_req, if_gnt, dm_gnt} !== {1'b1, !g[i], g[i]}) begin
               n_fails++;
               $display("[TB] FAIL starve_gnt%0d: got %b, want %b", i, {mem_req, if_gnt, dm_gnt}, {1'b1, !g[i], g[i]});
            end
            n_checks++;
            if (mem_addr !== (g[i] ? 32'h300 : 32'h400)) begin
               n_fails++;
               $display("[TB] FAIL starve_addr%0d: got %h, want %h", i, mem_addr, (g[i] ? 32'h300 : 32'h400));
            end
         end
         if (i > 0) begin
            n_checks++;
            if ({if_rvalid, dm_rvalid} !== {!g[i-1], g[i-1]}) begin
               n_fails++;
               $display("[TB] FAIL starve_rsp%0d: got %b, want %b", i, {if_rvalid, dm_rvalid}, {!g[i-1], g[i-1]});
            end
         end
      end
   endtask

   task automatic test_lock();
      tick();
      mem_rvalid = 0; if_req = 1; if_addr = 32'h500; dm_req = 0; mem_gnt = 0;
      #1;
      n_checks++;
      if ({mem_req, if_gnt, dm_gnt} !== 3'b100 || mem_addr !== 32'h500) begin
         n_fails++;
         $display("[TB] FAIL lock_start: got %b/%h, want 100/00000500", {mem_req, if_gnt, dm_gnt}, mem_addr);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         dm_req = 1; dm_we = 1; dm_funct3 = 3'b010; dm_addr = 32'h600; dm_wdata = 32'h55;
         #1;
         n_checks++;
         if ({mem_req, if_gnt, dm_gnt, mem_we} !== 4'b1000 || mem_addr !== 32'h500) begin
            n_fails++;
            $display("[TB] FAIL lock_hold%0d: got %b/%h, want 1000/00000500", i, {mem_req, if_gnt, dm_gnt, mem_we}, mem_addr);
         end
      end
      tick();
      mem_gnt = 1;
      #1;
      n_checks++;
      if ({mem_req, if_gnt, dm_gnt} !== 3'b110 || mem_addr !== 32'h500) begin
         n_fails++;
         $display("[TB] FAIL lock_release: got %b/%h, want 110/00000500", {mem_req, if_gnt, dm_gnt}, mem_addr);
      end
      tick();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_A5A5;
      #1;
      n_checks++;
      if ({dm_gnt, if_gnt, mem_we} !== 3'b101 || mem_addr !== 32'h600) begin
         n_fails++;
         $display("[TB] FAIL lock_next: got %b/%h, want 101/00000600", {dm_gnt, if_gnt, mem_we}, mem_addr);
      end
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'hA5A5_A5A5) begin
         n_fails++;
         $display("[TB] FAIL lock_rsp_if: got %b/%h, want 10/a5a5a5a5", {if_rvalid, dm_rvalid}, if_rdata);
      end
      tick();
      dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rdata = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b01 || dm_rdata !== 32'h0) begin
         n_fails++;
         $display("[TB] FAIL lock_rsp_dm: got %b/%h, want 01/00000000", {if_rvalid, dm_rvalid}, dm_rdata);
      end
   endtask

   // Two accepted fetches fill the pipe; the third waits until one returns.
   task automatic test_full();
      tick();
      mem_rvalid = 0; if_req = 1; if_addr = 32'h10B; mem_gnt = 1;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1 || mem_addr !== 32'h108) begin
         n_fails++;
         $display("[TB] FAIL full_first: got %b/%h, want 1/00000108", if_gnt, mem_addr);
      end
      tick();
      #1;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL full_second: got %b, want 1", if_gnt);
      end
      tick();
      #1;
      n_checks++;
      if ({mem_req, if_gnt} !== 2'b00) begin
         n_fails++;
         $display("[TB] FAIL full_block: got %b, want 00", {mem_req, if_gnt});
      end
      tick();
      mem_rvalid = 1; mem_rdata = 32'h1;
      #1;
      n_checks++;
      if ({mem_req, if_rvalid} !== 2'b01) begin
         n_fails++;
         $display("[TB] FAIL full_pop: got %b, want 01", {mem_req, if_rvalid});
      end
      tick();
      mem_rdata = 32'h2;
      #1;
      n_checks++;
      if ({mem_req, if_gnt, if_rvalid} !== 3'b111) begin
         n_fails++;
         $display("[TB] FAIL full_resume: got %b, want 111", {mem_req, if_gnt, if_rvalid});
      end
      tick();
      if_req = 0; mem_rdata = 32'h3;
      #1;
      n_checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h3) begin
         n_fails++;
         $display("[TB] FAIL full_last: got %b/%h, want 1/00000003", if_rvalid, if_rdata);
      end
      tick();
      mem_rdata = 32'h4;
      #1;
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b00) begin
         n_fails++;
         $display("[TB] FAIL full_extra_rvalid: got %b, want 00", {if_rvalid, dm_rvalid});
      end
   endtask

   task automatic test_reset_midflight();
      tick();
      mem_rvalid = 0; if_req = 1; if_addr = 32'h700; mem_gnt = 1;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL mid_fetch: got %b, want 1", if_gnt);
      end
      tick();
      if_req = 0; dm_req = 1; dm_we = 0; dm_funct3 = 3'b010; dm_addr = 32'h800; mem_gnt = 0;
      #1;
      n_checks++;
      if ({mem_req, dm_gnt} !== 2'b10) begin
         n_fails++;
         $display("[TB] FAIL mid_stall: got %b, want 10", {mem_req, dm_gnt});
      end
      tick();
      dm_req = 0; rst_n = 0; mem_rvalid = 1; mem_rdata = 32'h77;
      #1;
      n_checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b00) begin
         n_fails++;
         $display("[TB] FAIL mid_drop: got %b, want 00", {if_rvalid, dm_rvalid});
      end
      tick();
      rst_n = 1; if_req = 1; if_addr = 32'h900;
      #1;
      n_checks++;
      if ({mem_req, if_gnt, if_rvalid} !== 3'b100 || mem_addr !== 32'h900) begin
         n_fails++;
         $display("[TB] FAIL mid_unlock: got %b/%h, want 100/00000900", {mem_req, if_gnt, if_rvalid}, mem_addr);
      end
      tick();
      if_req = 0; mem_rvalid = 0;
   endtask

`ifdef MEM_ALIGN_CHK_EN
   task automatic test_align();
      tick();
      if_req = 1; if_addr = 32'h100; mem_gnt = 1; mem_rvalid = 0;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL align_fetch: got %b, want 1", if_gnt);
      end
      tick();
      if_req = 0; dm_req = 1; dm_we = 0; dm_funct3 = 3'b010; dm_addr = 32'h11;
      #1;
      n_checks++;
      if ({mem_req, dm_gnt} !== 2'b00) begin
         n_fails++;
         $display("[TB] FAIL align_wait: got %b, want 00", {mem_req, dm_gnt});
      end
      tick();
      mem_rvalid = 1; mem_rdata = 32'h42;
      #1;
      n_checks++;
      if ({if_rvalid, dm_gnt, mem_req} !== 3'b100) begin
         n_fails++;
         $display("[TB] FAIL align_drain: got %b, want 100", {if_rvalid, dm_gnt, mem_req});
      end
      tick();
      mem_rvalid = 0;
      #1;
      n_checks++;
      if ({dm_gnt, mem_req} !== 2'b10) begin
         n_fails++;
         $display("[TB] FAIL align_gnt: got %b, want 10", {dm_gnt, mem_req});
      end
      tick();
      dm_req = 0;
      #1;
      n_checks++;
      if ({dm_rvalid, dm_err} !== 2'b11 || dm_rdata !== 32'h0) begin
         n_fails++;
         $display("[TB] FAIL align_err: got %b/%h, want 11/00000000", {dm_rvalid, dm_err}, dm_rdata);
      end
      tick();
      #1;
      n_checks++;
      if (dm_rvalid !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL align_done: got %b, want 0", dm_rvalid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_loads();
      test_stores();
      test_starvation();
      test_lock();
      test_full();
      test_reset_midflight();
`ifdef MEM_ALIGN_CHK_EN
      test_align();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
